wb_arbiter2: RTL and testbench
==============================

# wb_arbiter2

Two-master Wishbone B4 pipelined arbiter. It sits in front of the register slave core and shares that slave between two bus masters, for example the CPU port and the debug/DMA port. It does round-robin arbitration per bus cycle, tracks outstanding transactions with a bounded counter, and runs a response watchdog that aborts a hung slave cycle with `err`. Ownership is held for the whole `cyc` of the granted master.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, address width
- `DATA_WIDTH`, 32, data width
- `GRANULE`, 8, bits per select lane; `SEL_WIDTH = DATA_WIDTH/GRANULE` (localparam)
- `MAX_OUTSTANDING`, 4, maximum accepted-but-unanswered requests (≥1)
- `TIMEOUT`, 255, cycles without a response before abort (≥2)

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  reset, asynchronous assert, active-low
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 controls
- `m0_adr_i`  in  ADDR_WIDTH;  `m0_dat_i`  in  DATA_WIDTH;  `m0_sel_i`  in  SEL_WIDTH
- `m0_dat_o`  out  DATA_WIDTH  read data
- `m0_ack_o`, `m0_err_o`, `m0_stall_o`  out  1 each
- `m1_*`  same set as `m0_*`, for master 1
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to slave
- `s_adr_o`  out  ADDR_WIDTH;  `s_dat_o`  out  DATA_WIDTH;  `s_sel_o`  out  SEL_WIDTH
- `s_dat_i`  in  DATA_WIDTH;  `s_ack_i`, `s_err_i`, `s_stall_i`  in  1 each

## Operation
- **Registered state:**
  - `state` ∈ {IDLE, OWN, ABORT}
  - `owner` (1 bit)
  - `last` (1 bit, master served most recently)
  - `outst` (0..MAX_OUTSTANDING)
  - `wdog` (0..TIMEOUT)
- **IDLE:**
  - Outputs: `s_cyc_o = s_stb_o = 0`; both `mX_stall_o = 1`; all `ack`/`err` are 0.
  - One `cyc_i` high → that master becomes `owner`, next state OWN.
  - Both high → `owner = !last`.
  - On grant, `last <= owner`, `outst <= 0`, `wdog <= 0`.
- **OWN:**
  - Slave request outputs are muxed combinationally from the owner's `adr`/`dat`/`sel`/`we`.
  - `s_cyc_o = owner.cyc_i`.
  - `full = (outst == MAX_OUTSTANDING)`.
  - `s_stb_o = owner.stb_i & !full`; `owner.stall_o = s_stall_i | full`.
  - Non-owner: `stall_o = 1`, `ack_o = err_o = 0`.
  - `owner.ack_o = s_ack_i`; `owner.err_o = s_err_i`.
  - Request accepted when `s_stb_o & !s_stall_i` → `outst + 1`.
  - Response (`s_ack_i | s_err_i`) → `outst - 1`.
  - Accept and response in the same cycle → `outst` unchanged.
  - A response while `outst == 0` is dropped: not routed, no underflow.
  - `owner.cyc_i` low → next state IDLE. Outstanding responses are abandoned: `outst <= 0`, and later slave responses are ignored.
- **Watchdog:**
  - While OWN and `outst > 0`: `wdog` increments each cycle with no response and clears on any response.
  - With `outst == 0`: `wdog` holds 0.
  - `wdog` reaching TIMEOUT-1 with no response that cycle:
    - `owner.err_o = 1` for that cycle only;
    - next state ABORT; `outst <= 0`.
- **ABORT:**
  - Outputs: `s_cyc_o = s_stb_o = 0`; `owner.stall_o = 1`; all `ack`/`err` are 0; slave responses are ignored.
  - Exits to IDLE when `owner.cyc_i` is low.
- `m0_dat_o = m1_dat_o = s_dat_i` unconditionally; only `ack` qualifies the data.
- Simultaneous `s_ack_i` and `s_err_i` is passed through as received; only one response is counted.

## Timing
- **Reset values (`rst_ni` low, effective immediately, asynchronous):**
  - state IDLE, `owner = 0`, `last = 1` (so master 0 wins the first tie), `outst = 0`, `wdog = 0`.
  - Outputs: `s_cyc_o = 0`, `s_stb_o = 0`, `mX_ack_o = 0`, `mX_err_o = 0`, `mX_stall_o = 1`.
  - Reset mid-transaction: all of the above; in-flight requests are abandoned.
- **Grant latency:** `cyc_i` sampled high at edge N → `s_cyc_o` high after edge N. The first request can be accepted in cycle N+1.
- **Pass-through timing:** `stb`, `stall` and response paths are combinational, zero cycles added.
- **Release:** owner `cyc_i` low → `s_cyc_o` low in the same cycle.
  - The other master can be granted at the edge that enters IDLE + 1, so there is at least one dead cycle between owners.
- **Back-to-back:** the same master reissuing `cyc` after one IDLE cycle, while the other requests, loses to the other master (round-robin).
- **Watchdog:** the `err` pulse occurs exactly TIMEOUT cycles after the last response or the first acceptance, whichever is later.

## Test plan
1. **Single master:** m0 issues 3 pipelined writes (adr 0x0004/0x0008/0x000C) with immediate acks → `s_cyc_o` high one cycle after `cyc`; 3 `m0_ack_o` pulses; `outst` returns to 0; `m1_stall_o` held at 1 throughout.
2. **Tie and round-robin:** after reset, both masters raise `cyc` at the same edge → m0 granted. m0 drops `cyc`, m1 still requesting → m1 granted one IDLE cycle later. Both request again → m0 granted.
3. **Outstanding limit:** MAX_OUTSTANDING=4, slave withholds `ack` → after 4 accepts `m0_stall_o = 1` and `s_stb_o = 0`. One `ack` → stall drops, a 5th request is accepted; `outst` stays at 4.
4. **Watchdog:** TIMEOUT=8, one accepted read with no `ack` → `m0_err_o` pulses 8 cycles after acceptance; `s_cyc_o = 0` while in ABORT. m0 drops `cyc` → IDLE. A late `s_ack_i` is not routed to either master.
5. **Edge cases:** `s_err_i` on the 2nd of 3 requests → `m0_err_o` pulse and `outst` decremented. A simultaneous accept and `ack` leaves `outst` unchanged.
6. **Async reset mid-burst:** `rst_ni` low between clock edges with `outst = 2` → `s_cyc_o` is 0 and both stalls are 1 before the next edge. After release, state is IDLE and `outst = 0`.

Source files
------------

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master Wishbone B4 pipelined arbiter in front of a single
// slave. Round-robin grant per bus cycle, bounded outstanding-request counter,
// and a response watchdog that aborts a hung slave cycle with err.
module wb_arbiter2 #(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int GRANULE         = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT         = 255,
  localparam int SEL_WIDTH      = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  // master 0
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  input  logic [SEL_WIDTH-1:0]  m0_sel_i,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_stall_o,
  // master 1
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  input  logic [SEL_WIDTH-1:0]  m1_sel_i,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_stall_o,
  // slave
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  output logic [SEL_WIDTH-1:0]  s_sel_o,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_stall_i
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  typedef struct packed {
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
    logic [SEL_WIDTH-1:0]  sel;
  } wb_req_t;

  state_t        state;
  logic          owner;
  logic          last;
  logic [OW-1:0] outst;
  logic [WW-1:0] wdog;

  wb_req_t [1:0] mreq;
  wb_req_t       oreq;
  logic    [1:0] m_ack, m_err, m_stall;
  logic          own, full, busy, resp, accept, rsp_take, wd_fire, win;

  assign mreq[0] = {m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i};
  assign mreq[1] = {m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i};
  assign oreq    = mreq[owner];

  assign own  = (state == OWN);
  assign full = (outst == OUT_MAX);
  assign busy = (outst != '0);
  assign resp = s_ack_i | s_err_i;

  // Slave request side: owner's request muxed straight through. stb is also
  // qualified by cyc so the slave never sees a strobe outside a bus cycle.
  assign s_cyc_o = own & oreq.cyc;
  assign s_stb_o = own & oreq.cyc & oreq.stb & ~full;
  assign s_we_o  = oreq.we;
  assign s_adr_o = oreq.adr;
  assign s_dat_o = oreq.dat;
  assign s_sel_o = oreq.sel;

  // A response only counts (and is only routed) when something is in flight.
  assign accept   = s_stb_o & ~s_stall_i;
  assign rsp_take = own & busy & resp;
  assign wd_fire  = own & busy & ~resp & (wdog == WD_LAST);

  // Tie goes to whoever was not served last; otherwise the lone requester.
  assign win = (m0_cyc_i & m1_cyc_i) ? ~last : m1_cyc_i;

  for (genvar g = 0; g < 2; g++) begin : g_master
    logic mine;
    assign mine       = own & (owner == 1'(g));
    assign m_stall[g] = ~mine | s_stall_i | full;
    assign m_ack[g]   = mine & rsp_take & s_ack_i;
    assign m_err[g]   = mine & ((rsp_take & s_err_i) | wd_fire);
  end

  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;
  assign m0_ack_o   = m_ack[0];
  assign m1_ack_o   = m_ack[1];
  assign m0_err_o   = m_err[0];
  assign m1_err_o   = m_err[1];
  assign m0_stall_o = m_stall[0];
  assign m1_stall_o = m_stall[1];

  // Arbitration FSM with outstanding counter and response watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      outst <= '0;
      wdog  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_cyc_i | m1_cyc_i) begin
            state <= OWN;
            owner <= win;
            last  <= win;
            outst <= '0;
            wdog  <= '0;
          end
        end
        OWN: begin
          if (!oreq.cyc) begin
            // Owner gave up the cycle: anything still in flight is abandoned.
            state <= IDLE;
            outst <= '0;
            wdog  <= '0;
          end else if (wd_fire) begin
            state <= ABORT;
            outst <= '0;
            wdog  <= '0;
          end else begin
            if (accept && !rsp_take)      outst <= outst + 1'b1;
            else if (!accept && rsp_take) outst <= outst - 1'b1;
            if (!busy || resp) wdog <= '0;
            else               wdog <= wdog + 1'b1;
          end
        end
        ABORT: begin
          if (!oreq.cyc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level model (pending-request queue and
// last-progress timestamp for the watchdog).
module tb_wb_arbiter2;
  localparam int AW = 16, DW = 32, SW = 4, MAXO = 4, TO = 8;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic [1:0] mc, ms, mw;
  logic [1:0][AW-1:0] ma;
  logic [1:0][DW-1:0] md;
  logic [1:0][SW-1:0] msel;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic m0_ack_o, m0_err_o, m0_stall_o, m1_ack_o, m1_err_o, m1_stall_o;
  logic s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o, s_dat_i;
  logic [SW-1:0] s_sel_o;
  logic s_ack_i, s_err_i, s_stall_i;

  always #5 clk_i = ~clk_i;

  wb_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8),
                .MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_we_i(mw[0]), .m0_adr_i(ma[0]),
    .m0_dat_i(md[0]), .m0_sel_i(msel[0]), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_stall_o(m0_stall_o),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_we_i(mw[1]), .m1_adr_i(ma[1]),
    .m1_dat_i(md[1]), .m1_sel_i(msel[1]), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_stall_o(m1_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle / 1 owned / 2 aborting.
  int ph, mo, ml, prog, now;
  int pend[$];

  task automatic mdl_reset();
    ph = 0; mo = 0; ml = 1; prog = 0;
    pend.delete();
  endtask

  function automatic bit timeout_now();
    return (ph == 1) && (pend.size() > 0) && !(s_ack_i | s_err_i) &&
           (now - prog == TO);
  endfunction

  task automatic compare();
    bit own, busy, full, tmo, mine;
    logic [1:0] e_stall, e_ack, e_err;
    own  = (ph == 1);
    busy = pend.size() > 0;
    full = pend.size() == MAXO;
    tmo  = timeout_now();
    for (int g = 0; g < 2; g++) begin
      mine = own && (mo == g);
      e_stall[g] = !mine || s_stall_i || full;
      e_ack[g]   = mine && busy && s_ack_i;
      e_err[g]   = mine && ((busy && s_err_i) || tmo);
    end
    chk("s_cyc", s_cyc_o, own && mc[mo]);
    chk("s_stb", s_stb_o, own && mc[mo] && ms[mo] && !full);
    chk("m0_stall", m0_stall_o, e_stall[0]);
    chk("m1_stall", m1_stall_o, e_stall[1]);
    chk("m0_ack", m0_ack_o, e_ack[0]);
    chk("m1_ack", m1_ack_o, e_ack[1]);
    chk("m0_err", m0_err_o, e_err[0]);
    chk("m1_err", m1_err_o, e_err[1]);
    chk("m0_dat", m0_dat_o, s_dat_i);
    chk("m1_dat", m1_dat_o, s_dat_i);
    if (own) begin
      chk("s_adr", s_adr_o, ma[mo]);
      chk("s_dat", s_dat_o, md[mo]);
      chk("s_sel", s_sel_o, msel[mo]);
      chk("s_we", s_we_o, mw[mo]);
    end
  endtask

  task automatic mdl_update();
    bit tmo, rsp, acc;
    tmo = timeout_now();
    case (ph)
      0: if (mc != 2'b00) begin
           mo = (mc == 2'b11) ? 1 - ml : (mc[0] ? 0 : 1);
           ml = mo;
           pend.delete();
           ph = 1;
         end
      1: if (!mc[mo]) begin
           ph = 0; pend.delete();
         end else if (tmo) begin
           ph = 2; pend.delete();
         end else begin
           rsp = (s_ack_i || s_err_i) && pend.size() > 0;
           acc = ms[mo] && pend.size() < MAXO && !s_stall_i;
           if (rsp) begin void'(pend.pop_front()); prog = now; end
           if (acc) begin
             if (pend.size() == 0) prog = now;
             pend.push_back(int'(ma[mo]));
           end
         end
      default: if (!mc[mo]) ph = 0;
    endcase
    now++;
  endtask

  // Check mid-cycle, advance model at the edge, return at the next negedge.
  task automatic cycle();
    #1 compare();
    @(posedge clk_i);
    mdl_update();
    @(negedge clk_i);
  endtask

  task automatic quiet();
    s_ack_i = 0; s_err_i = 0; s_stall_i = 0;
  endtask

  bit hung = 0;
  task automatic rand_drive();
    for (int g = 0; g < 2; g++) begin
      if (!mc[g]) mc[g] = ($urandom_range(3) == 0);
      else if ($urandom_range(15) == 0) mc[g] = 1'b0;
      ms[g]   = mc[g] & 1'($urandom);
      mw[g]   = 1'($urandom);
      ma[g]   = AW'($urandom);
      md[g]   = DW'($urandom);
      msel[g] = SW'($urandom);
    end
    if ($urandom_range(39) == 0) hung = !hung;
    s_ack_i   = !hung && 1'($urandom);
    s_err_i   = !hung && ($urandom_range(7) == 0);
    s_stall_i = ($urandom_range(3) == 0);
    s_dat_i   = DW'($urandom);
  endtask

  initial begin
    mc = '0; ms = '0; mw = '0; ma = '0; md = '0; msel = '0;
    s_dat_i = 32'hDEAD_BEEF;
    quiet();
    now = 0;
    mdl_reset();
    #2;
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_m0_stall", m0_stall_o, 1);
    chk("rst_m1_stall", m1_stall_o, 1);
    chk("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    @(negedge clk_i);
    rst_ni = 1;

    // Tie after reset goes to m0, then round-robin hands over to m1.
    mc = 2'b11; ma[0] = 16'h0004; ma[1] = 16'h0100;
    cycle();
    #1 chk("tie_adr", s_adr_o, 16'h0004);
    chk("tie_m1_stall", m1_stall_o, 1);
    cycle();
    mc = 2'b10; cycle();
    cycle();
    #1 chk("rr_adr", s_adr_o, 16'h0100);
    chk("rr_s_cyc", s_cyc_o, 1);
    cycle();
    mc = 2'b00; cycle();
    mc = 2'b11; cycle();
    #1 chk("rr_back_adr", s_adr_o, 16'h0004);
    cycle();
    mc = 2'b00; cycle();

    // Outstanding limit: four accepts with no response, then one ack refills.
    mc = 2'b01; cycle();
    ms = 2'b01;
    for (int i = 0; i < MAXO; i++) begin ma[0] = AW'(4 * (i + 1)); cycle(); end
    #1 chk("full_stall", m0_stall_o, 1);
    chk("full_stb", s_stb_o, 0);
    s_ack_i = 1; cycle();
    s_ack_i = 0;
    #1 chk("refill_stall", m0_stall_o, 0);
    chk("refill_stb", s_stb_o, 1);
    cycle();
    ms = 2'b00; mc = 2'b00; cycle();
    cycle();

    // Watchdog: one accepted request, no response, err exactly TO cycles on.
    mc = 2'b01; cycle();
    ms = 2'b01; cycle();
    ms = 2'b00;
    for (int k = 1; k <= TO; k++) begin
      #1 chk(k < TO ? "wd_quiet" : "wd_pulse", m0_err_o, k == TO);
      cycle();
    end
    #1 chk("abort_s_cyc", s_cyc_o, 0);
    s_ack_i = 1; cycle();
    cycle();
    mc = 2'b00; cycle();
    s_ack_i = 0; cycle();

    // Async reset with two requests in flight.
    mc = 2'b01; cycle();
    ms = 2'b01; cycle(); cycle();
    ms = 2'b00;
    #2 rst_ni = 0;
    #1 chk("arst_s_cyc", s_cyc_o, 0);
    chk("arst_s_stb", s_stb_o, 0);
    chk("arst_m0_stall", m0_stall_o, 1);
    chk("arst_m1_stall", m1_stall_o, 1);
    mdl_reset();
    @(negedge clk_i);
    rst_ni = 1; mc = 2'b00;
    cycle();
    mc = 2'b01; s_ack_i = 1; cycle();
    #1 chk("arst_no_stale_ack", m0_ack_o, 0);
    cycle();
    s_ack_i = 0; mc = 2'b00; cycle();
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rand_drive();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
